ring_buff_ctrl_mc: RTL

Multi-channel ring-buffer controller: a parametrised successor to the single-queue ring-buffer controller. It manages NUM_CH independent circular queues of NUM_ENTRY entries each, partitioned inside one shared storage array. It sits between a producer/consumer pair and a single RAM with one write port and one read port, generating addresses and status. It adds per-channel guarded accept/reject, programmable almost-full/almost-empty levels, per-channel flush and sticky overflow/underflow flags.

---
 rtl/ring_buff_ctrl_mc_if.sv | 48 ++++
 rtl/ring_buff_ctrl_mc.sv | 111 +++++++++++
 2 files changed

// File: rtl/ring_buff_ctrl_mc_if.sv
// ring_buff_ctrl_mc_if
// Bundles the request, acknowledge, address and status signals of the
// multi-channel ring-buffer controller.
//   master : producer/consumer side (drives requests and flush, sees status)
//   slave  : controller side (returns acks, RAM addresses and per-channel status)
// Ports of the controller:
//   I_We/I_WCh, I_Re/I_RCh : write/read request and target channel
//   I_Flush                : per-channel flush bitmask
//   O_WAck/O_RAck          : request accepted this cycle
//   O_WAddr/O_RAddr        : {channel, pointer} RAM addresses
//   O_Full/O_Empty/O_AFull/O_AEmpty/O_Num : per-channel level status
//   O_Ovf/O_Udf            : sticky overflow/underflow flags
interface ring_buff_ctrl_mc_if #(
  parameter int NUM_ENTRY = 16,
  parameter int NUM_CH    = 4
);
  localparam int EW = $clog2(NUM_ENTRY);
  localparam int CW = $clog2(NUM_CH);

  logic                     I_We;
  logic [CW-1:0]            I_WCh;
  logic                     I_Re;
  logic [CW-1:0]            I_RCh;
  logic [NUM_CH-1:0]        I_Flush;
  logic                     O_WAck;
  logic                     O_RAck;
  logic [CW+EW-1:0]         O_WAddr;
  logic [CW+EW-1:0]         O_RAddr;
  logic [NUM_CH-1:0]        O_Full;
  logic [NUM_CH-1:0]        O_Empty;
  logic [NUM_CH-1:0]        O_AFull;
  logic [NUM_CH-1:0]        O_AEmpty;
  logic [NUM_CH*(EW+1)-1:0] O_Num;
  logic [NUM_CH-1:0]        O_Ovf;
  logic [NUM_CH-1:0]        O_Udf;

  modport master (
    output I_We, I_WCh, I_Re, I_RCh, I_Flush,
    input  O_WAck, O_RAck, O_WAddr, O_RAddr, O_Full, O_Empty,
           O_AFull, O_AEmpty, O_Num, O_Ovf, O_Udf
  );

  modport slave (
    input  I_We, I_WCh, I_Re, I_RCh, I_Flush,
    output O_WAck, O_RAck, O_WAddr, O_RAddr, O_Full, O_Empty,
           O_AFull, O_AEmpty, O_Num, O_Ovf, O_Udf
  );
endinterface

// File: rtl/ring_buff_ctrl_mc.sv
// ring_buff_ctrl_mc
// Address/status controller for NUM_CH independent circular queues of
// NUM_ENTRY entries each, sharing one RAM with a write port and a read port.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset, overrides flush and requests
//   bus   : ring_buff_ctrl_mc_if.slave (requests, acks, addresses, status)
// Acks and addresses are combinational in the request cycle; counts, status
// and sticky flags follow at the next edge.
module ring_buff_ctrl_mc #(
  parameter int NUM_ENTRY = 16,
  parameter int NUM_CH    = 4,
  parameter int AF_LEVEL  = NUM_ENTRY - 2,
  parameter int AE_LEVEL  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  ring_buff_ctrl_mc_if.slave   bus
);
  localparam int EW = $clog2(NUM_ENTRY);
  localparam int CW = $clog2(NUM_CH);
  localparam logic [EW:0] FULL_CNT = (EW+1)'(NUM_ENTRY);
  localparam logic [EW:0] AF_CNT   = (EW+1)'(AF_LEVEL);
  localparam logic [EW:0] AE_CNT   = (EW+1)'(AE_LEVEL);

  logic [EW-1:0]     wptr_q [NUM_CH];
  logic [EW-1:0]     wptr_d [NUM_CH];
  logic [EW-1:0]     rptr_q [NUM_CH];
  logic [EW-1:0]     rptr_d [NUM_CH];
  logic [EW:0]       cnt_q  [NUM_CH];
  logic [EW:0]       cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] udf_q, udf_d;

  logic wr_full, rd_empty, wack, rack;

  // Guards look only at the registered count, so a same-cycle read never
  // frees room for a write into a full channel (and vice versa).
  always_comb begin
    wr_full  = (cnt_q[bus.I_WCh] == FULL_CNT);
    rd_empty = (cnt_q[bus.I_RCh] == '0);
    wack     = bus.I_We & ~wr_full  & ~bus.I_Flush[bus.I_WCh];
    rack     = bus.I_Re & ~rd_empty & ~bus.I_Flush[bus.I_RCh];
  end

  always_comb begin
    logic wr_hit, rd_hit;
    ovf_d = ovf_q;
    udf_d = udf_q;
    for (int c = 0; c < NUM_CH; c++) begin
      wptr_d[c] = wptr_q[c];
      rptr_d[c] = rptr_q[c];
      cnt_d[c]  = cnt_q[c];
      wr_hit    = wack && (bus.I_WCh == CW'(c));
      rd_hit    = rack && (bus.I_RCh == CW'(c));
      if (bus.I_Flush[c]) begin
        wptr_d[c] = '0;
        rptr_d[c] = '0;
        cnt_d[c]  = '0;
        ovf_d[c]  = 1'b0;
        udf_d[c]  = 1'b0;
      end else begin
        if (wr_hit) wptr_d[c] = wptr_q[c] + 1'b1;
        if (rd_hit) rptr_d[c] = rptr_q[c] + 1'b1;
        if (wr_hit && !rd_hit)      cnt_d[c] = cnt_q[c] + 1'b1;
        else if (rd_hit && !wr_hit) cnt_d[c] = cnt_q[c] - 1'b1;
        if (bus.I_We && (bus.I_WCh == CW'(c)) && (cnt_q[c] == FULL_CNT)) ovf_d[c] = 1'b1;
        if (bus.I_Re && (bus.I_RCh == CW'(c)) && (cnt_q[c] == '0))       udf_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  always_comb begin
    bus.O_WAck   = wack;
    bus.O_RAck   = rack;
    bus.O_WAddr  = {bus.I_WCh, wptr_q[bus.I_WCh]};
    bus.O_RAddr  = {bus.I_RCh, rptr_q[bus.I_RCh]};
    bus.O_Ovf    = ovf_q;
    bus.O_Udf    = udf_q;
    bus.O_Full   = '0;
    bus.O_Empty  = '0;
    bus.O_AFull  = '0;
    bus.O_AEmpty = '0;
    bus.O_Num    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.O_Full[c]            = (cnt_q[c] == FULL_CNT);
      bus.O_Empty[c]           = (cnt_q[c] == '0);
      bus.O_AFull[c]           = (cnt_q[c] >= AF_CNT);
      bus.O_AEmpty[c]          = (cnt_q[c] <= AE_CNT);
      bus.O_Num[c*(EW+1) +: EW+1] = cnt_q[c];
    end
  end
endmodule
